// File: rtl/counter_prog_pkg.sv
// Shared types for the programmable iteration counter used by the MDR
// control FSMs.
//   cnt_state_e  : counter sequencing state (IDLE / RUN / DONE)
//   CNT_DIR_*    : encodings of the latched count direction
package counter_prog_pkg;

  typedef enum logic [1:0] {
    CNT_IDLE = 2'd0,
    CNT_RUN  = 2'd1,
    CNT_DONE = 2'd2
  } cnt_state_e;

  localparam logic CNT_DIR_DOWN = 1'b0;
  localparam logic CNT_DIR_UP   = 1'b1;

endpackage : counter_prog_pkg

// File: rtl/counter_prog.sv
// Programmable up/down iteration counter with runtime-loadable span,
// one-shot or auto-reload operation and hold-or-reload pause behaviour.
// The count always stays within 0..limit-1.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous reset, active-high
//   i_load       latch i_limit / i_dir, count = start, go IDLE
//   i_limit      count span (0 is treated as 1)
//   i_dir        0 = down (limit-1 -> 0), 1 = up (0 -> limit-1)
//   i_autoreload 1 = wrap to start at terminal, 0 = stop in DONE
//   i_hold       with i_enable low: 1 = freeze, 0 = reload start and go IDLE
//   i_clear      count = start, go IDLE
//   i_enable     count enable
//   o_count      registered count
//   o_tc         count is at the terminal value (combinational)
//   o_wrap       one-cycle pulse following an auto-reload
//   o_busy       state is RUN
//   o_done       state is DONE
module counter_prog
  import counter_prog_pkg::*;
#(
  parameter int WIDTH         = 8,
  parameter int DEFAULT_LIMIT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_limit,
  input  logic             i_dir,
  input  logic             i_autoreload,
  input  logic             i_hold,
  input  logic             i_clear,
  input  logic             i_enable,
  output logic [WIDTH-1:0] o_count,
  output logic             o_tc,
  output logic             o_wrap,
  output logic             o_busy,
  output logic             o_done
);

  localparam logic [WIDTH-1:0] RST_LIMIT = WIDTH'(DEFAULT_LIMIT);
  localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);

  cnt_state_e       state_reg, state_next;
  logic [WIDTH-1:0] count_reg, count_next;
  logic [WIDTH-1:0] limit_reg, limit_next;
  logic             dir_reg,   dir_next;
  logic             wrap_reg,  wrap_next;

  logic [WIDTH-1:0] start_val, term_val;
  logic [WIDTH-1:0] load_limit, load_start;
  logic             at_term;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= CNT_IDLE;
      count_reg <= RST_LIMIT - ONE;
      limit_reg <= RST_LIMIT;
      dir_reg   <= CNT_DIR_DOWN;
      wrap_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      limit_reg <= limit_next;
      dir_reg   <= dir_next;
      wrap_reg  <= wrap_next;
    end
  end

  always_comb begin
    // Endpoints of the current span; limit_reg is never 0 so limit-1 is safe.
    start_val  = (dir_reg == CNT_DIR_UP) ? '0 : limit_reg - ONE;
    term_val   = (dir_reg == CNT_DIR_UP) ? limit_reg - ONE : '0;
    at_term    = (count_reg == term_val);

    // Start value for the span being loaded this cycle.
    load_limit = (i_limit == '0) ? ONE : i_limit;
    load_start = (i_dir == CNT_DIR_UP) ? '0 : load_limit - ONE;

    state_next = state_reg;
    count_next = count_reg;
    limit_next = limit_reg;
    dir_next   = dir_reg;
    wrap_next  = 1'b0;

    if (i_load) begin
      limit_next = load_limit;
      dir_next   = i_dir;
      count_next = load_start;
      state_next = CNT_IDLE;
    end else if (i_clear) begin
      count_next = start_val;
      state_next = CNT_IDLE;
    end else if (i_enable) begin
      // DONE ignores enable; it is left only via load, clear or reload-pause.
      if (state_reg != CNT_DONE) begin
        if (!at_term) begin
          count_next = (dir_reg == CNT_DIR_UP) ? count_reg + ONE : count_reg - ONE;
          state_next = CNT_RUN;
        end else if (i_autoreload) begin
          count_next = start_val;
          wrap_next  = 1'b1;
          state_next = CNT_RUN;
        end else begin
          state_next = CNT_DONE;
        end
      end
    end else if (!i_hold) begin
      // Legacy pause: drop back to the start of the span.
      count_next = start_val;
      state_next = CNT_IDLE;
    end
  end

  assign o_count = count_reg;
  assign o_tc    = (count_reg == term_val);
  assign o_wrap  = wrap_reg;
  assign o_busy  = (state_reg == CNT_RUN);
  assign o_done  = (state_reg == CNT_DONE);

endmodule : counter_prog

// File: tb/tb_counter_prog.sv
module tb_counter_prog;

  logic       clk = 1'b0;
  logic       rst;
  logic       i_load, i_dir, i_autoreload, i_hold, i_clear, i_enable;
  logic [7:0] i_limit;
  logic [7:0] o_count;
  logic       o_tc, o_wrap, o_busy, o_done;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  counter_prog #(.WIDTH(8), .DEFAULT_LIMIT(16)) dut (
    .clk(clk), .rst(rst),
    .i_load(i_load), .i_limit(i_limit), .i_dir(i_dir),
    .i_autoreload(i_autoreload), .i_hold(i_hold), .i_clear(i_clear),
    .i_enable(i_enable),
    .o_count(o_count), .o_tc(o_tc), .o_wrap(o_wrap),
    .o_busy(o_busy), .o_done(o_done)
  );

  typedef struct {
    logic       load;
    logic [7:0] limit;
    logic       dir;
    logic       autoreload;
    logic       hold;
    logic       clear;
    logic       enable;
    logic [7:0] e_count;
    logic       e_tc, e_wrap, e_busy, e_done;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic ld, input logic [7:0] lim, input logic dr,
                     input logic ar, input logic hd, input logic cl, input logic en,
                     input logic [7:0] ec, input logic et, input logic ew,
                     input logic eb, input logic ed);
    vec_t v;
    v.load = ld; v.limit = lim; v.dir = dr; v.autoreload = ar; v.hold = hd;
    v.clear = cl; v.enable = en; v.e_count = ec; v.e_tc = et; v.e_wrap = ew;
    v.e_busy = eb; v.e_done = ed;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic ld, input logic [7:0] lim, input logic dr,
                       input logic ar, input logic hd, input logic cl, input logic en);
    i_load = ld; i_limit = lim; i_dir = dr; i_autoreload = ar;
    i_hold = hd; i_clear = cl; i_enable = en;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [7:0] ec, input logic et,
                       input logic ew, input logic eb, input logic ed);
    n_vec++;
    if ({o_count, o_tc, o_wrap, o_busy, o_done} !== {ec, et, ew, eb, ed}) begin
      n_bad++;
      $display("FAIL %s: got count=%0d tc=%b wrap=%b busy=%b done=%b, want count=%0d tc=%b wrap=%b busy=%b done=%b",
               nm, o_count, o_tc, o_wrap, o_busy, o_done, ec, et, ew, eb, ed);
    end else begin
      $display("ok   %s: count=%0d tc=%b wrap=%b busy=%b done=%b",
               nm, o_count, o_tc, o_wrap, o_busy, o_done);
    end
  endtask

  initial begin
    // ---------------- vector table ----------------
    // add(load, limit, dir, auto, hold, clear, en, count, tc, wrap, busy, done)

    // 1: default limit 16, down, auto-reload
    for (int i = 1; i <= 15; i++)
      add(0, 0, 0, 1, 1, 0, 1, 8'(15 - i), (i == 15), 0, 1, 0);
    add(0, 0, 0, 1, 1, 0, 1, 15, 0, 1, 1, 0);   // reload, wrap pulse
    add(0, 0, 0, 1, 1, 0, 1, 14, 0, 0, 1, 0);   // pulse gone

    // 2: limit 5, up, one-shot; enable ignored in load cycle
    add(1, 5, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 1, 0, 1, 1, 0, 0, 1, 0);
    add(0, 0, 0, 0, 1, 0, 1, 2, 0, 0, 1, 0);
    add(0, 0, 0, 0, 1, 0, 1, 3, 0, 0, 1, 0);
    add(0, 0, 0, 0, 1, 0, 1, 4, 1, 0, 1, 0);
    add(0, 0, 0, 0, 1, 0, 1, 4, 1, 0, 0, 1);   // enters DONE
    add(0, 0, 0, 0, 1, 0, 1, 4, 1, 0, 0, 1);
    add(0, 0, 0, 0, 1, 0, 1, 4, 1, 0, 0, 1);
    add(0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0);   // clear beats enable

    // 3: limit 16 down, hold then legacy reload
    add(1, 16, 0, 1, 1, 0, 0, 15, 0, 0, 0, 0);
    for (int i = 1; i <= 5; i++)
      add(0, 0, 0, 1, 1, 0, 1, 8'(15 - i), 0, 0, 1, 0);
    for (int i = 0; i < 3; i++)
      add(0, 0, 0, 1, 1, 0, 0, 10, 0, 0, 1, 0);
    add(0, 0, 0, 1, 1, 0, 1, 9, 0, 0, 1, 0);
    add(0, 0, 0, 1, 0, 0, 0, 15, 0, 0, 0, 0);

    // 4: limit 0 -> 1, auto-reload wraps every enabled cycle
    add(1, 0, 0, 1, 1, 0, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++)
      add(0, 0, 0, 1, 1, 0, 1, 0, 1, 1, 1, 0);
    add(0, 0, 0, 1, 1, 0, 0, 0, 1, 0, 1, 0);   // wrap drops when paused

    // ---------------- reset state ----------------
    drive(0, 0, 0, 1, 1, 0, 0);
    rst = 1'b1;
    #12;
    check("reset", 15, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // ---------------- table-driven section ----------------
    foreach (vecs[k]) begin
      drive(vecs[k].load, vecs[k].limit, vecs[k].dir, vecs[k].autoreload,
            vecs[k].hold, vecs[k].clear, vecs[k].enable);
      tick();
      check($sformatf("vec%0d", k), vecs[k].e_count, vecs[k].e_tc,
            vecs[k].e_wrap, vecs[k].e_busy, vecs[k].e_done);
    end

    // ---------------- 5: asynchronous reset mid-run ----------------
    drive(1, 16, 0, 1, 1, 0, 0);
    tick();
    check("t5_load", 15, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 1, 0, 1);
    for (int i = 1; i <= 8; i++) tick();
    check("t5_at7", 7, 0, 0, 1, 0);
    #3;
    rst = 1'b1;
    #1;
    check("t5_async_rst", 15, 0, 0, 0, 0);
    #1;
    rst = 1'b0;
    drive(1, 9, 1, 1, 1, 1, 1);
    tick();
    check("t5_load_wins", 0, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 1, 0, 1);
    tick();
    check("t5_up_step", 1, 0, 0, 1, 0);

    // ---------------- 6: full-span one-shot down from 254 ----------------
    drive(1, 255, 0, 0, 1, 0, 0);
    tick();
    check("t6_load", 254, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 0, 1);
    for (int i = 1; i <= 254; i++) begin
      tick();
      check($sformatf("t6_step%0d", i), 8'(254 - i), (i == 254), 0, 1, 0);
    end
    tick();
    check("t6_done", 0, 1, 0, 0, 1);
    tick();
    check("t6_done_hold", 0, 1, 0, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule : tb_counter_prog
